risc_trace_buffer: RTL and testbench
====================================

// Module: risc_trace_buffer
// PURPOSE
//  Parametrised on-chip execution tracer for the KGP-RISC core; generalises printing the result, PC and instruction once per core clock.
//  Captures one {pc, instr, res} record per enabled core cycle into a circular buffer of DEPTH entries.
//  Also counts cycles and detects a halt: the PC stays unchanged for HALT_REPEAT captures.
//  Sits beside the RISC top level, tapping the PC, the datapath instruction and resOut; read back by bench or debug logic.
// PARAMETERS
//  ADDR_W       32  width of captured PC
//  INSTR_W      32  width of captured instruction
//  DATA_W       32  width of captured result
//  DEPTH        16  buffer entries; power of two, >=2
//  HALT_REPEAT   4  consecutive same-PC captures that assert halted; >=2
//  CYC_W        32  width of the saturating cycle counter
// PORTS
//  CLK       in   1                core clock, rising edge
//  RST       in   1                asynchronous, active-low reset
//  en        in   1                capture enable (core running)
//  clr       in   1                synchronous clear of buffer, counter and halt state
//  pc        in   ADDR_W           current PC
//  instr     in   INSTR_W          current instruction
//  res       in   DATA_W           current result (resOut)
//  rd_req    in   1                read request
//  rd_idx    in   clog2(DEPTH)     entry index; 0 = oldest valid record
//  rd_valid  out  1                read response strobe, one cycle
//  rd_err    out  1                with rd_valid: rd_idx >= count, data forced 0
//  rd_pc     out  ADDR_W           read data: PC
//  rd_instr  out  INSTR_W          read data: instruction
//  rd_res    out  DATA_W           read data: result
//  count     out  clog2(DEPTH)+1   valid records, saturates at DEPTH
//  wrapped   out  1                at least one record overwritten since reset/clr
//  halted    out  1                halt detected; sticky until reset/clr
//  cycles    out  CYC_W            enabled cycles since reset/clr, saturating
// BEHAVIOUR
//  Reset (RST=0, async): wr_ptr, count, wrapped, halted, cycles, repeat counter, rd_valid, rd_err, rd_* = 0.
//    Buffer contents are don't-care.
//  Capture: at a rising edge with en=1, clr=0, halted=0:
//    write {pc,instr,res} at wr_ptr; wr_ptr+1 mod DEPTH; count+1 up to DEPTH.
//    Writing while count==DEPTH overwrites the oldest record and sets wrapped.
//  cycles: +1 on every edge with en=1 and clr=0, including while halted; holds at all-ones.
//  Halt detection: keep the previous captured PC and a repeat counter.
//    Repeat counter = 1 on the first capture after reset/clr.
//    Each capture: pc == previous PC -> repeat counter +1; otherwise repeat counter = 1.
//    The capture that brings the repeat counter to HALT_REPEAT is written, and halted is set at the same edge.
//    While halted: no further captures; the buffer is frozen for readout.
//  clr=1: same state effect as reset, applied synchronously; clr has priority over capture and read.
//  Read: fixed 1-cycle latency. rd_req sampled at edge N -> rd_valid=1 for the cycle after edge N.
//    Physical address = (wr_ptr - count + rd_idx) mod DEPTH, using wr_ptr and count before edge N.
//    Simultaneous capture and read at the same edge: the read returns pre-write memory. The new record is invisible to that read.
//    rd_idx >= count (including count==0): rd_err=1 and rd_pc/rd_instr/rd_res = 0.
//    With rd_req=0: rd_valid=0, rd_err=0; rd_* hold their last value.
//    Back-to-back rd_req each cycle gives one response per cycle.
//  Fully synchronous to CLK; no combinational path from inputs to outputs.
// CONFIGURATION
//  TRACE_DISPLAY_EN defined: on every capture edge, simulation-only $display:
//    "resOut = %b, PC = %b, Instr = %b" (res, pc, instr).
//    Once on the edge halted rises: "HALT pc=%h cycles=%0d".
//  Not defined: no $display; the logic is identical and synthesizable.
// TESTING
//  Reset, 3 captures pc=0,4,8, then rd_idx=0..3 -> pc 0,4,8 returned; idx 3 gives rd_err=1, data 0; count=3.
//  DEPTH=16, 20 captures pc=4*k (k=0..19) -> count=16, wrapped=1; rd_idx=0 -> pc=16; rd_idx=15 -> pc=76.
//  pc=0x20 held with HALT_REPEAT=4 -> halted rises at the 4th capture; count stops; cycles keeps counting.
//  Capture pc=0x40 and rd_req idx=count-1 at the same edge -> returns the previous newest record, not 0x40.
//  clr or RST low mid-stream after 5 captures -> count=0, halted=0, cycles=0; the next capture lands at entry 0.
//  en=0 for 10 cycles -> no captures; cycles unchanged; repeat counter unchanged.

Source files
------------

// File: rtl/risc_trace_buffer.sv
// Execution tracer: circular {pc, instr, res} record buffer with cycle counter and halt detect.
// Optional macro TRACE_DISPLAY_EN adds a simulation-only printout of each capture and of the halt.
module risc_trace_buffer #(
   parameter int ADDR_W      = 32,
   parameter int INSTR_W     = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 16,
   parameter int HALT_REPEAT = 4,
   parameter int CYC_W       = 32
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       en,
   input  logic                       clr,
   input  logic [ADDR_W-1:0]          pc,
   input  logic [INSTR_W-1:0]         instr,
   input  logic [DATA_W-1:0]          res,
   input  logic                       rd_req,
   input  logic [$clog2(DEPTH)-1:0]   rd_idx,
   output logic                       rd_valid,
   output logic                       rd_err,
   output logic [ADDR_W-1:0]          rd_pc,
   output logic [INSTR_W-1:0]         rd_instr,
   output logic [DATA_W-1:0]          rd_res,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       wrapped,
   output logic                       halted,
   output logic [CYC_W-1:0]           cycles
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;
   localparam int REP_W = $clog2(HALT_REPEAT + 1);

   logic [ADDR_W-1:0]  mem_pc    [DEPTH];
   logic [INSTR_W-1:0] mem_instr [DEPTH];
   logic [DATA_W-1:0]  mem_res   [DEPTH];

   logic [IDX_W-1:0]  wr_ptr;
   logic [IDX_W-1:0]  rd_addr;
   logic [ADDR_W-1:0] prev_pc;
   logic [REP_W-1:0]  rep_cnt;
   logic [REP_W-1:0]  rep_next;
   logic              capture;
   logic              rd_hit;

   assign capture = en & ~clr & ~halted;
   // When count==DEPTH its low bits are zero, so the oldest record sits at wr_ptr.
   assign rd_addr = wr_ptr - count[IDX_W-1:0] + rd_idx;
   assign rd_hit  = {1'b0, rd_idx} < count;

   // rep_cnt==0 only before the first capture after reset/clr.
   always_comb begin
      rep_next = REP_W'(1);
      if (rep_cnt != '0 && pc == prev_pc)
         rep_next = rep_cnt + REP_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (capture) begin
         mem_pc[wr_ptr]    <= pc;
         mem_instr[wr_ptr] <= instr;
         mem_res[wr_ptr]   <= res;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr   <= '0;
         count    <= '0;
         wrapped  <= 1'b0;
         halted   <= 1'b0;
         cycles   <= '0;
         prev_pc  <= '0;
         rep_cnt  <= '0;
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
         rd_pc    <= '0;
         rd_instr <= '0;
         rd_res   <= '0;
      end else if (clr) begin
         wr_ptr   <= '0;
         count    <= '0;
         wrapped  <= 1'b0;
         halted   <= 1'b0;
         cycles   <= '0;
         prev_pc  <= '0;
         rep_cnt  <= '0;
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
         rd_pc    <= '0;
         rd_instr <= '0;
         rd_res   <= '0;
      end else begin
         rd_valid <= rd_req;
         rd_err   <= rd_req & ~rd_hit;
         // Memory reads here see pre-write contents, hiding a same-edge capture.
         if (rd_req) begin
            rd_pc    <= rd_hit ? mem_pc[rd_addr]    : '0;
            rd_instr <= rd_hit ? mem_instr[rd_addr] : '0;
            rd_res   <= rd_hit ? mem_res[rd_addr]   : '0;
         end
         if (en && cycles != '1)
            cycles <= cycles + CYC_W'(1);
         if (capture) begin
            wr_ptr  <= wr_ptr + IDX_W'(1);
            prev_pc <= pc;
            rep_cnt <= rep_next;
            if (count != CNT_W'(DEPTH))
               count <= count + CNT_W'(1);
            else
               wrapped <= 1'b1;
            if (rep_next == REP_W'(HALT_REPEAT))
               halted <= 1'b1;
         end
      end
   end

`ifdef TRACE_DISPLAY_EN
   always @(posedge CLK) begin
      if (RST && capture) begin
         $display("resOut = %b, PC = %b, Instr = %b", res, pc, instr);
         if (rep_next == REP_W'(HALT_REPEAT))
            $display("HALT pc=%h cycles=%0d", pc,
                     (cycles == '1) ? cycles : cycles + CYC_W'(1));
      end
   end
`else
`endif

endmodule

// File: tb/tb_risc_trace_buffer.sv
// Directed bench for risc_trace_buffer: read responses go through an expected queue
// checked by a monitor; status outputs are checked directly after each phase.
module tb_risc_trace_buffer;

   localparam int DEPTH = 16;
   localparam int IDX_W = $clog2(DEPTH);
   localparam int EXP_W = 1 + 32 + 32 + 32;

   logic             CLK;
   logic             RST;
   logic             en;
   logic             clr;
   logic [31:0]      pc;
   logic [31:0]      instr;
   logic [31:0]      res;
   logic             rd_req;
   logic [IDX_W-1:0] rd_idx;
   logic             rd_valid;
   logic             rd_err;
   logic [31:0]      rd_pc;
   logic [31:0]      rd_instr;
   logic [31:0]      rd_res;
   logic [IDX_W:0]   count;
   logic             wrapped;
   logic             halted;
   logic [31:0]      cycles;

   logic [EXP_W-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   risc_trace_buffer #(
      .ADDR_W(32), .INSTR_W(32), .DATA_W(32),
      .DEPTH(DEPTH), .HALT_REPEAT(4), .CYC_W(32)
   ) dut (
      .CLK(CLK), .RST(RST), .en(en), .clr(clr),
      .pc(pc), .instr(instr), .res(res),
      .rd_req(rd_req), .rd_idx(rd_idx),
      .rd_valid(rd_valid), .rd_err(rd_err),
      .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_res(rd_res),
      .count(count), .wrapped(wrapped), .halted(halted), .cycles(cycles)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, actual=running required=finished");
      $fatal(1, "timeout");
   end

   // stimulus data generators (tag each record by its pc)
   function automatic logic [31:0] instr_of(input logic [31:0] p);
      return 32'hC000_0000 | p;
   endfunction

   function automatic logic [31:0] res_of(input logic [31:0] p);
      return 32'h0BAD_0000 + p;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // driver tasks
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic cap(input logic [31:0] p);
      en = 1'b1; pc = p; instr = instr_of(p); res = res_of(p);
      step();
      en = 1'b0;
   endtask

   task automatic push_rd(input int idx, input logic [31:0] p, input logic err);
      rd_req = 1'b1;
      rd_idx = IDX_W'(idx);
      if (err) exp_q.push_back({1'b1, 96'd0});
      else     exp_q.push_back({1'b0, p, instr_of(p), res_of(p)});
   endtask

   task automatic rd(input int idx, input logic [31:0] p, input logic err);
      push_rd(idx, p, err);
      step();
      rd_req = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic check_status(input string tag, input int c, input logic w,
                               input logic h, input int cy);
      check({tag, "_count"},   64'(count),   64'(c));
      check({tag, "_wrapped"}, 64'(wrapped), 64'(w));
      check({tag, "_halted"},  64'(halted),  64'(h));
      check({tag, "_cycles"},  64'(cycles),  64'(cy));
   endtask

   // scoreboard monitor
   always @(negedge CLK) begin
      logic [EXP_W-1:0] e;
      if (RST && rd_valid) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rd_unexpected: actual=rd_valid required=no response at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            check("rd_err",   64'(rd_err),   64'(e[96]));
            check("rd_pc",    64'(rd_pc),    64'(e[95:64]));
            check("rd_instr", 64'(rd_instr), 64'(e[63:32]));
            check("rd_res",   64'(rd_res),   64'(e[31:0]));
         end
      end
   end

   initial begin
      RST = 1'b0; en = 1'b0; clr = 1'b0; pc = '0; instr = '0; res = '0;
      rd_req = 1'b0; rd_idx = '0;
      #22;
      check_status("reset", 0, 1'b0, 1'b0, 0);
      check("reset_rd_valid", 64'(rd_valid), 64'd0);
      check("reset_rd_pc", 64'(rd_pc), 64'd0);
      @(negedge CLK);
      RST = 1'b1;
      step();

      // three captures then readback including an out-of-range index
      cap(32'h0); cap(32'h4); cap(32'h8);
      check_status("three", 3, 1'b0, 1'b0, 3);
      rd(0, 32'h0, 1'b0);
      rd(1, 32'h4, 1'b0);
      rd(2, 32'h8, 1'b0);
      rd(3, 32'h0, 1'b1);
      idle(2);

      // same-edge capture and read of newest: read sees the older record
      en = 1'b1; pc = 32'h40; instr = instr_of(32'h40); res = res_of(32'h40);
      push_rd(2, 32'h8, 1'b0);
      step();
      en = 1'b0; rd_req = 1'b0;
      check_status("same_edge", 4, 1'b0, 1'b0, 4);

      // idle gap leaves cycles and repeat counter untouched
      idle(10);
      check_status("idle", 4, 1'b0, 1'b0, 4);
      cap(32'h40); cap(32'h40);
      check_status("rep3", 6, 1'b0, 1'b0, 6);
      cap(32'h40);
      check_status("halt_after_gap", 7, 1'b0, 1'b1, 7);
      cap(32'h44); cap(32'h48); cap(32'h4C);
      check_status("frozen", 7, 1'b0, 1'b1, 10);
      rd(6, 32'h40, 1'b0);
      rd(7, 32'h0, 1'b1);
      idle(2);

      // clear wins over a concurrent capture
      clr = 1'b1; en = 1'b1; pc = 32'h99;
      step();
      clr = 1'b0; en = 1'b0;
      check_status("clr", 0, 1'b0, 1'b0, 0);
      rd(0, 32'h0, 1'b1);
      idle(1);

      // held pc: halted rises on the fourth capture
      cap(32'h20); cap(32'h20); cap(32'h20);
      check_status("held3", 3, 1'b0, 1'b0, 3);
      cap(32'h20);
      check_status("held4", 4, 1'b0, 1'b1, 4);
      cap(32'h24); cap(32'h28); cap(32'h2C);
      check_status("held_frozen", 4, 1'b0, 1'b1, 7);
      rd(0, 32'h20, 1'b0);
      rd(3, 32'h20, 1'b0);
      idle(2);

      // wrap: 20 captures into 16 entries
      clr = 1'b1;
      step();
      clr = 1'b0;
      for (int k = 0; k < 20; k++) cap(32'(4 * k));
      check_status("wrap", 16, 1'b1, 1'b0, 20);
      rd(0,  32'd16, 1'b0);
      rd(5,  32'd36, 1'b0);
      rd(15, 32'd76, 1'b0);
      idle(3);
      check("rd_pc_hold", 64'(rd_pc), 64'd76);
      check("rd_err_idle", 64'(rd_err), 64'd0);

      // asynchronous reset mid-stream
      for (int k = 0; k < 5; k++) cap(32'h200 + 32'(4 * k));
      #2;
      RST = 1'b0;
      #1;
      check_status("async_rst", 0, 1'b0, 1'b0, 0);
      check("async_rst_rd_pc", 64'(rd_pc), 64'd0);
      @(negedge CLK);
      RST = 1'b1;
      step();
      cap(32'h100);
      check_status("post_rst", 1, 1'b0, 1'b0, 1);
      rd(0, 32'h100, 1'b0);
      rd(1, 32'h0, 1'b1);

      // drain outstanding responses
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
      check("exp_q_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
